// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32 datapath.
// Drives the register/PC/memory strobes and the operand selects for each
// state. The instruction class is captured in DECODE.
// Build option: define MEM_READY_EN so that FETCH and MEM stall on
// mem_ready_i, with a wait counter that traps after WAIT_TIMEOUT cycles.
//
// state  | meaning
// FETCH  | memory read of the instruction, IR load on completion
// DECODE | classify opcode, trap on illegal encodings
// EXEC   | ALU operation; a branch resolves here
// MEM    | data load/store; a store retires here
// WB     | register writeback plus PC update
// TRAP   | sticky fault, all strobes off until reset
module multicycle_ctrl #(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        branch_taken_i,
    input  logic        mem_ready_i,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic [2:0]  imm_sel_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        reg_write_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic        fault_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR
    } cls_e;

    state_e state_q, state_d;
    cls_e   cls_q, cls_d;
    logic   fault_q, fault_d;
    logic   illegal;
    logic   xfer_done;
    logic   xfer_timeout;

    // Only the opcode field steers control; the other instruction bits are datapath-only.
    logic unused_sig;
    assign unused_sig = ^{instr_i[31:7], mem_ready_i, WAIT_TIMEOUT[0]};

`ifdef MEM_READY_EN
    localparam int CW = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    logic [CW-1:0] wait_q, wait_d;

    // Transfer completion and timeout; a ready on the terminal cycle still wins.
    always_comb begin
        xfer_done    = mem_ready_i;
        xfer_timeout = !mem_ready_i && (wait_q == CW'(WAIT_TIMEOUT));
    end

    // Count stalled cycles while in a memory state, clear whenever the state changes.
    always_comb begin
        wait_d = '0;
        if ((state_q == FETCH || state_q == MEM) && !xfer_done && !xfer_timeout)
            wait_d = wait_q + CW'(1);
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
    end
`else
    // Memory always answers in the same cycle.
    always_comb begin
        xfer_done    = 1'b1;
        xfer_timeout = 1'b0;
    end
`endif

    // Opcode classification; anything unlisted (including low bits != 11) is illegal.
    always_comb begin
        cls_d   = C_R;
        illegal = 1'b0;
        case (instr_i[6:0])
            7'b0110011: cls_d = C_R;
            7'b0010011: cls_d = C_IALU;
            7'b0000011: cls_d = C_LOAD;
            7'b0100011: cls_d = C_STORE;
            7'b1100011: cls_d = C_BRANCH;
            7'b0110111: cls_d = C_LUI;
            7'b0010111: cls_d = C_AUIPC;
            7'b1101111: cls_d = C_JAL;
            7'b1100111: cls_d = C_JALR;
            default:    illegal = 1'b1;
        endcase
    end

    // State, class and fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cls_q   <= C_R;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_q == DECODE) cls_q <= cls_d;
        end
    end

    assign fault_d = fault_q | (state_d == TRAP);
    assign state_o = state_q;
    assign fault_o = fault_q;

    // Immediate format follows the captured class; forced to 0 while in reset.
    always_comb begin
        imm_sel_o = 3'b000;
        if (rst_n) begin
            case (cls_q)
                C_IALU, C_LOAD, C_JALR: imm_sel_o = 3'b000;
                C_STORE:                imm_sel_o = 3'b001;
                C_BRANCH:               imm_sel_o = 3'b010;
                C_LUI, C_AUIPC:         imm_sel_o = 3'b011;
                C_JAL:                  imm_sel_o = 3'b100;
                default:                imm_sel_o = 3'b000;
            endcase
        end
    end

    // Next state and per-state strobes; everything is held low during reset.
    always_comb begin
        state_d     = state_q;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 2'b00;
        alu_src_a_o = 2'b00;
        alu_src_b_o = 2'b00;
        alu_op_o    = 2'b00;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        reg_write_o = 1'b0;
        wb_sel_o    = 2'b00;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_req_o = 1'b1;
                    if (xfer_done) begin
                        ir_write_o = 1'b1;
                        state_d    = DECODE;
                    end else if (xfer_timeout) begin
                        state_d = TRAP;
                    end
                end
                DECODE: state_d = illegal ? TRAP : EXEC;
                EXEC: begin
                    case (cls_q)
                        C_R:                     alu_op_o = 2'b10;
                        C_IALU: begin alu_src_b_o = 2'b01; alu_op_o = 2'b10; end
                        C_LOAD, C_STORE, C_JALR: alu_src_b_o = 2'b01;
                        C_LUI:   begin alu_src_a_o = 2'b10; alu_src_b_o = 2'b01; end
                        C_AUIPC: begin alu_src_a_o = 2'b01; alu_src_b_o = 2'b01; end
                        C_BRANCH:                alu_op_o = 2'b01;
                        default:                 alu_op_o = 2'b00;
                    endcase
                    if (cls_q == C_BRANCH) begin
                        pc_write_o = 1'b1;
                        pc_src_o   = branch_taken_i ? 2'b01 : 2'b00;
                        state_d    = FETCH;
                    end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                        state_d = MEM;
                    end else begin
                        state_d = WB;
                    end
                end
                MEM: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = (cls_q == C_STORE);
                    if (xfer_done) begin
                        if (cls_q == C_STORE) begin
                            pc_write_o = 1'b1;
                            state_d    = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end else if (xfer_timeout) begin
                        state_d = TRAP;
                    end
                end
                WB: begin
                    reg_write_o = 1'b1;
                    pc_write_o  = 1'b1;
                    case (cls_q)
                        C_LOAD:  wb_sel_o = 2'b01;
                        C_JAL:   begin wb_sel_o = 2'b10; pc_src_o = 2'b01; end
                        C_JALR:  begin wb_sel_o = 2'b10; pc_src_o = 2'b10; end
                        default: wb_sel_o = 2'b00;
                    endcase
                    state_d = FETCH;
                end
                TRAP:    state_d = TRAP;
                default: state_d = TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream against a per-instruction
// model of the expected state sequence and strobes.
module tb_multicycle_ctrl;

    localparam int WT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ready;
    logic        ir_write_o, pc_write_o, mem_req_o, mem_we_o, reg_write_o, fault_o;
    logic [1:0]  pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, wb_sel_o;
    logic [2:0]  imm_sel_o, state_o;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.WAIT_TIMEOUT(WT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_i        (instr),
        .branch_taken_i (branch_taken),
        .mem_ready_i    (mem_ready),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .pc_src_o       (pc_src_o),
        .imm_sel_o      (imm_sel_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_o       (alu_op_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .reg_write_o    (reg_write_o),
        .wb_sel_o       (wb_sel_o),
        .state_o        (state_o),
        .fault_o        (fault_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Class codes: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, -1 illegal.
    function automatic logic [6:0] opcode_of(input int c);
        case (c)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b0100011;
            4: return 7'b1100011;
            5: return 7'b0110111;
            6: return 7'b0010111;
            7: return 7'b1101111;
            default: return 7'b1100111;
        endcase
    endfunction

    function automatic int cls_of(input logic [31:0] ins);
        for (int k = 0; k < 9; k++)
            if (ins[6:0] == opcode_of(k)) return k;
        return -1;
    endfunction

    function automatic logic [31:0] mk_instr(input int c);
        logic [31:0] r;
        r = $urandom;
        if (c >= 0) r[6:0] = opcode_of(c);
        else if (cls_of(r) >= 0) r[0] = 1'b0;
        return r;
    endfunction

    function automatic int imm_of(input int c);
        case (c)
            3: return 1;
            4: return 2;
            5, 6: return 3;
            7: return 4;
            default: return 0;
        endcase
    endfunction

    // {alu_src_a, alu_src_b, alu_op}; 6'h3f marks a class with no defined selects.
    function automatic logic [5:0] ops_of(input int c);
        case (c)
            0: return 6'b00_00_10;
            1: return 6'b00_01_10;
            2, 3, 8: return 6'b00_01_00;
            5: return 6'b10_01_00;
            6: return 6'b01_01_00;
            4: return 6'b00_00_01;
            default: return 6'h3f;
        endcase
    endfunction

    function automatic logic rdy(input bit last);
`ifdef MEM_READY_EN
        return last;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    // strb = {ir_write, pc_write, reg_write, mem_req, mem_we}
    task automatic step(input string tag, input int st, input logic [4:0] strb, input int c,
                        input logic [1:0] pcs, input logic [1:0] wbs);
        logic [5:0] ops;
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".strb"}, {27'b0, ir_write_o, pc_write_o, reg_write_o, mem_req_o, mem_we_o},
              {27'b0, strb});
        check({tag, ".fault"}, 32'(fault_o), (st == 7) ? 32'd1 : 32'd0);
        if (st >= 2 && st <= 4 && c >= 0) check({tag, ".imm"}, 32'(imm_sel_o), 32'(imm_of(c)));
        if (st == 2) begin
            ops = ops_of(c);
            if (ops != 6'h3f)
                check({tag, ".alu"}, {26'b0, alu_src_a_o, alu_src_b_o, alu_op_o}, {26'b0, ops});
        end
        if (strb[3]) check({tag, ".pc_src"}, 32'(pc_src_o), 32'(pcs));
        if (strb[2]) check({tag, ".wb_sel"}, 32'(wb_sel_o), 32'(wbs));
    endtask

    // Reset asserted between edges, held over one rising edge, released before the next.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 check("rst.async", {10'b0, state_o, fault_o, ir_write_o, pc_write_o, reg_write_o,
                 mem_req_o, mem_we_o, pc_src_o, imm_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                 wb_sel_o}, 32'd0);
        @(posedge clk);
        #1 check("rst.clk", {10'b0, state_o, fault_o, ir_write_o, pc_write_o, reg_write_o,
                 mem_req_o, mem_we_o, pc_src_o, imm_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                 wb_sel_o}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic adv(inout int cyc, input int rst_at, output bit ab);
        @(negedge clk);
        cyc++;
        ab = 1'b0;
        if (cyc == rst_at) begin
            do_reset();
            ab = 1'b1;
        end
    endtask

    // One instruction: df/dm are stall cycles in FETCH/MEM, rst_at aborts at that cycle.
    task automatic run_instr(input logic [31:0] ins, input bit taken, input int df,
                             input int dm, input int rst_at);
        int c, cyc;
        bit ab;
        logic [1:0] pcs, wbs;
        c = cls_of(ins);
        cyc = 0;
        instr = ins;
        branch_taken = taken;
`ifndef MEM_READY_EN
        df = 0;
        dm = 0;
`endif
        for (int i = 0; i <= df; i++) begin
            mem_ready = rdy(i == df);
            #1 step("fetch", 0, {(i == df), 4'b0010}, c, 2'b00, 2'b00);
            adv(cyc, rst_at, ab);
            if (ab) return;
        end
        mem_ready = rdy(1'b0);
        #1 step("decode", 1, 5'b0, c, 2'b00, 2'b00);
        adv(cyc, rst_at, ab);
        if (ab) return;
        if (c < 0) begin
            for (int i = 0; i < 3; i++) begin
                #1 step("trap", 7, 5'b0, c, 2'b00, 2'b00);
                adv(cyc, rst_at, ab);
                if (ab) return;
            end
            do_reset();
            return;
        end
        pcs = (c == 4 && taken) ? 2'b01 : 2'b00;
        #1 step("exec", 2, {1'b0, (c == 4), 3'b000}, c, pcs, 2'b00);
        adv(cyc, rst_at, ab);
        if (ab || c == 4) return;
        if (c == 2 || c == 3) begin
            for (int i = 0; i <= dm; i++) begin
                mem_ready = rdy(i == dm);
                #1 step("mem", 3, {1'b0, (c == 3 && i == dm), 1'b0, 1'b1, (c == 3)}, c,
                        2'b00, 2'b00);
                adv(cyc, rst_at, ab);
                if (ab) return;
            end
            if (c == 3) return;
        end
        wbs = (c == 2) ? 2'b01 : (c == 7 || c == 8) ? 2'b10 : 2'b00;
        pcs = (c == 7) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
        #1 step("wb", 4, 5'b01100, c, pcs, wbs);
        adv(cyc, rst_at, ab);
    endtask

`ifdef MEM_READY_EN
    // Load whose data phase never gets ready: MEM lasts WT+1 cycles then traps.
    task automatic run_timeout();
        instr = 32'h0000A103;
        mem_ready = 1'b1;
        #1 step("to.fetch", 0, 5'b10010, 2, 2'b00, 2'b00);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 step("to.decode", 1, 5'b0, 2, 2'b00, 2'b00);
        @(negedge clk);
        #1 step("to.exec", 2, 5'b0, 2, 2'b00, 2'b00);
        @(negedge clk);
        for (int i = 0; i <= WT; i++) begin
            #1 step("to.mem", 3, 5'b00010, 2, 2'b00, 2'b00);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            #1 step("to.trap", 7, 5'b0, -1, 2'b00, 2'b00);
            @(negedge clk);
        end
        do_reset();
    endtask
`endif

    initial begin
        int c, df, dm, ra;
        rst_n = 1'b0;
        instr = 32'h0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        do_reset();

        run_instr(32'h00500093, 1'b0, 0, 0, -1);   // addi
        run_instr(32'h00208463, 1'b1, 0, 0, -1);   // beq taken
        run_instr(32'h00208463, 1'b0, 1, 0, -1);   // beq not taken
        run_instr(32'h0040006F, 1'b0, 0, 0, -1);   // jal
        run_instr(32'h0000A103, 1'b0, 0, 3, -1);   // lw, 3 stall cycles
        run_instr(32'h0020A023, 1'b0, 2, 1, -1);   // sw
        run_instr(32'h0000A103, 1'b0, WT, WT, -1); // ready on the last allowed cycle
        run_instr(32'hFFFFFFFF, 1'b0, 0, 0, -1);   // illegal -> trap -> reset
`ifdef MEM_READY_EN
        run_timeout();
`endif
        run_instr(32'h0000A103, 1'b0, 0, 5, 3);    // reset during MEM

        for (int n = 0; n < 200; n++) begin
            c  = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 8));
            df = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            dm = int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_instr(mk_instr(c), 1'($urandom_range(0, 1)), df, dm, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
